// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use detection.
// Define IDEX_PERF_CNT_EN to add the bubble and forwarding event counters.
module id_ex_stage #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_stall,
   input  logic              i_flush,
   input  logic              i_id_valid,
   input  logic [DATA_W-1:0] i_id_reg_a,
   input  logic [DATA_W-1:0] i_id_reg_b,
   input  logic [4:0]        i_id_rs,
   input  logic [4:0]        i_id_rt,
   input  logic [4:0]        i_id_rd,
   input  logic [15:0]       i_id_imm16,
   input  logic [4:0]        i_id_shamt,
   input  logic [3:0]        i_id_alu_ctrl,
   input  logic [6:0]        i_id_ctrl,
   input  logic              i_mem_fwd_wr,
   input  logic [4:0]        i_mem_fwd_rd,
   input  logic [DATA_W-1:0] i_mem_fwd_data,
   input  logic              i_wb_fwd_wr,
   input  logic [4:0]        i_wb_fwd_rd,
   input  logic [DATA_W-1:0] i_wb_fwd_data,
   output logic              o_load_use_stall,
   output logic              o_ex_valid,
   output logic [DATA_W-1:0] o_bus_a,
   output logic [DATA_W-1:0] o_bus_b,
   output logic [3:0]        o_alu_ctrl,
   output logic [DATA_W-1:0] o_ex_store_data,
   output logic [4:0]        o_ex_rd,
   output logic [3:0]        o_ex_ctrl
`ifdef IDEX_PERF_CNT_EN
   ,
   output logic [31:0]       o_bubble_cnt,
   output logic [31:0]       o_fwd_cnt
`endif
);

   // Control vector layout: {ALUSrc, ShiftSrc, SignExt, RegWrite, MemRead, MemWrite, MemToReg}
   localparam int unsigned CtlAluSrc   = 6;
   localparam int unsigned CtlShiftSrc = 5;
   localparam int unsigned CtlSignExt  = 4;
   localparam int unsigned CtlRegWrite = 3;
   localparam int unsigned CtlMemRead  = 2;
   localparam int unsigned CtlMemWrite = 1;

   logic              r_valid;
   logic [4:0]        r_rs;
   logic [4:0]        r_rt;
   logic [4:0]        r_rd;
   logic [DATA_W-1:0] r_reg_a;
   logic [DATA_W-1:0] r_reg_b;
   logic [15:0]       r_imm16;
   logic [4:0]        r_shamt;
   logic [3:0]        r_alu_ctrl;
   logic [6:0]        r_ctrl;

   logic              w_load_use;
   logic              w_bypass_a;
   logic              w_bypass_b;
   logic              w_mem_hit_a;
   logic              w_mem_hit_b;
   logic              w_wb_hit_a;
   logic              w_wb_hit_b;
   logic [DATA_W-1:0] w_fwd_a;
   logic [DATA_W-1:0] w_fwd_b;
   logic [DATA_W-1:0] w_imm_ext;

   assign w_load_use = r_valid && r_ctrl[CtlMemRead] && r_ctrl[CtlRegWrite] && (r_rd != 5'd0)
                       && i_id_valid
                       && ((r_rd == i_id_rs)
                           || ((r_rd == i_id_rt)
                               && (!i_id_ctrl[CtlAluSrc] || i_id_ctrl[CtlMemWrite])));

   // Write-back happening on the same edge as the load would otherwise be missed by the regfile.
   assign w_bypass_a = i_wb_fwd_wr && (i_wb_fwd_rd != 5'd0) && (i_wb_fwd_rd == i_id_rs);
   assign w_bypass_b = i_wb_fwd_wr && (i_wb_fwd_rd != 5'd0) && (i_wb_fwd_rd == i_id_rt);

   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_valid    <= 1'b0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_rd       <= '0;
         r_reg_a    <= '0;
         r_reg_b    <= '0;
         r_imm16    <= '0;
         r_shamt    <= '0;
         r_alu_ctrl <= '0;
         r_ctrl     <= '0;
      end else if (i_stall) begin
         r_valid <= r_valid;
      end else if (w_load_use) begin
         r_valid    <= 1'b0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_rd       <= '0;
         r_reg_a    <= '0;
         r_reg_b    <= '0;
         r_imm16    <= '0;
         r_shamt    <= '0;
         r_alu_ctrl <= '0;
         r_ctrl     <= '0;
      end else begin
         r_valid    <= i_id_valid;
         r_rs       <= i_id_rs;
         r_rt       <= i_id_rt;
         r_rd       <= i_id_rd;
         r_reg_a    <= w_bypass_a ? i_wb_fwd_data : i_id_reg_a;
         r_reg_b    <= w_bypass_b ? i_wb_fwd_data : i_id_reg_b;
         r_imm16    <= i_id_imm16;
         r_shamt    <= i_id_shamt;
         r_alu_ctrl <= i_id_alu_ctrl;
         r_ctrl     <= i_id_ctrl;
      end
   end

   assign w_mem_hit_a = i_mem_fwd_wr && (i_mem_fwd_rd != 5'd0) && (i_mem_fwd_rd == r_rs);
   assign w_mem_hit_b = i_mem_fwd_wr && (i_mem_fwd_rd != 5'd0) && (i_mem_fwd_rd == r_rt);
   assign w_wb_hit_a  = i_wb_fwd_wr && (i_wb_fwd_rd != 5'd0) && (i_wb_fwd_rd == r_rs);
   assign w_wb_hit_b  = i_wb_fwd_wr && (i_wb_fwd_rd != 5'd0) && (i_wb_fwd_rd == r_rt);

   // EX/MEM holds the younger result, so it wins over MEM/WB.
   assign w_fwd_a = w_mem_hit_a ? i_mem_fwd_data : (w_wb_hit_a ? i_wb_fwd_data : r_reg_a);
   assign w_fwd_b = w_mem_hit_b ? i_mem_fwd_data : (w_wb_hit_b ? i_wb_fwd_data : r_reg_b);

   assign w_imm_ext = r_ctrl[CtlSignExt] ? {{(DATA_W-16){r_imm16[15]}}, r_imm16}
                                         : {{(DATA_W-16){1'b0}}, r_imm16};

   assign o_load_use_stall = w_load_use;
   assign o_ex_valid       = r_valid;
   assign o_bus_a          = r_ctrl[CtlShiftSrc] ? {{(DATA_W-5){1'b0}}, r_shamt} : w_fwd_a;
   assign o_bus_b          = r_ctrl[CtlAluSrc] ? w_imm_ext : w_fwd_b;
   assign o_alu_ctrl       = r_alu_ctrl;
   assign o_ex_store_data  = w_fwd_b;
   assign o_ex_rd          = r_rd;
   assign o_ex_ctrl        = r_ctrl[3:0];

`ifdef IDEX_PERF_CNT_EN
   logic [31:0] r_bubble_cnt;
   logic [31:0] r_fwd_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_bubble_cnt <= '0;
         r_fwd_cnt    <= '0;
      end else begin
         // Only bubbles actually inserted count; flush and stall take precedence.
         if (!i_flush && !i_stall && w_load_use) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
         end
         if (r_valid && (w_mem_hit_a || w_mem_hit_b || w_wb_hit_a || w_wb_hit_b)) begin
            r_fwd_cnt <= r_fwd_cnt + 32'd1;
         end
      end
   end

   assign o_bubble_cnt = r_bubble_cnt;
   assign o_fwd_cnt    = r_fwd_cnt;
`endif

endmodule
